alu_mem_pipe_stage: RTL and testbench
=====================================

Name: alu_mem_pipe_stage

Overview:
- Parametrised EX->MEM pipeline stage between the ALU and data-memory stages of the 24-bit core.
- Every control and data field is registered with one cycle of latency.
- Adds a valid/ready handshake with a 2-entry skid buffer, so the MEM stage can backpressure without a combinational ready path to EX.
- Adds a synchronous flush for branch/exception squash, and a registered forwarding tap for the EX-stage bypass mux.

Parameters:
- DATA_W, 24, width of alu_result and write_data.
- DEST_W, 4, width of the destination register index.
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous squash of all held entries.
- in_valid  in  1  EX presents a valid instruction.
- in_ready  out  1  stage can accept this cycle.
- in_wb_en  in  1  writeback enable.
- in_mem_rd  in  1  memory read enable.
- in_mem_wr  in  1  memory write enable.
- in_dest  in  DEST_W  destination register.
- in_alu_result  in  DATA_W  ALU result / memory address.
- in_write_data  in  DATA_W  store data.
- out_valid  out  1  MEM-side entry valid.
- out_ready  in  1  MEM stage accepts this cycle.
- out_wb_en, out_mem_rd, out_mem_wr  out  1 each  registered controls.
- out_dest  out  DEST_W  registered destination.
- out_alu_result, out_write_data  out  DATA_W  registered data.
- fwd_valid  out  1  out_valid & out_wb_en & ~out_mem_rd.
- fwd_dest  out  DEST_W  equals out_dest.
- fwd_data  out  DATA_W  equals out_alu_result.
- stall_cnt  out  CNT_W  count of cycles with out_valid & ~out_ready, saturating.

Behaviour:
- Storage: a main register (drives out_*) and a skid register, each with its own valid bit.
- in_ready = ~skid_valid. It is a pure function of a flop and has no path from out_ready.
- Reset (rst=1 at edge):
  - main_valid=0, skid_valid=0.
  - All out_* payload fields=0, stall_cnt=0.
  - in_ready reads 1 the cycle after reset.
  - rst overrides flush and every handshake.
- Flush (flush=1, rst=0):
  - main_valid=0 and skid_valid=0 next cycle.
  - The in-flight input that cycle is discarded even if in_valid & in_ready.
  - Payload fields may hold stale values, but out_valid=0 and fwd_valid=0.
  - stall_cnt is unaffected.
- States are decoded from {skid_valid, main_valid}:
  - EMPTY (00):
    - in_valid -> load main, go FULL.
    - Otherwise stay EMPTY.
  - FULL (01):
    - out_ready & in_valid -> main <= input, stay FULL.
    - out_ready & ~in_valid -> EMPTY.
    - ~out_ready & in_valid -> skid <= input, go SKID.
    - ~out_ready & ~in_valid -> hold.
  - SKID (11), with in_ready=0 and input ignored:
    - out_ready -> main <= skid, skid_valid=0, go FULL.
    - Otherwise hold.
- Latency: an accepted input appears on out_* on the next cycle when the stage is not backpressured. Throughput is 1 per cycle with no bubbles while out_ready=1.
- Ordering is strictly FIFO; the skid entry is never overtaken.
- Payload in main and skid is written only on an accepting transfer. Held data stays bit-stable while out_valid & ~out_ready.
- stall_cnt increments by 1 every cycle with out_valid & ~out_ready, and saturates at 2^CNT_W-1 with no wrap.
- fwd_* is purely combinational from the main register. A load (out_mem_rd=1) never forwards.

Test Plan:
- Reset, then one beat: rst high 2 cycles, then in_valid=1, dest=4'h3, alu=24'h00_1234, wb=1, out_ready=1.
  -> out_valid=1 one cycle later with matching fields; fwd_valid=1, fwd_dest=3, fwd_data=24'h001234.
- Streaming: 8 back-to-back beats alu=1..8, out_ready=1.
  -> out_alu_result sequence 1..8 on consecutive cycles, in_ready always 1.
- Backpressure: stream alu=10,11,12 and drop out_ready after the first beat lands.
  -> main holds 10, skid holds 11, in_ready=0, 12 held upstream; stall_cnt increments each stalled cycle.
  -> On out_ready=1, outputs are 10,11,12 in order with no loss or duplicates.
- Flush while in SKID: flush=1 with in_valid=1, alu=24'hABCDEF.
  -> Next cycle out_valid=0, in_ready=1, fwd_valid=0; 24'hABCDEF never appears on out_*.
- Load does not forward: in_mem_rd=1, in_wb_en=1, dest=5.
  -> out_valid=1, fwd_valid=0.
- Saturation and reset priority:
  - Hold out_valid with out_ready=0 for 2^CNT_W+3 cycles (CNT_W=4) -> stall_cnt=15.
  - Assert rst and flush together -> all state and stall_cnt=0.

Source files
------------

// File: rtl/alu_mem_pipe_stage.sv
// EX->MEM pipeline stage for the 24-bit core.
// Holds one instruction in a main register that drives the MEM side, plus one
// skid entry that absorbs the beat in flight when MEM stalls. in_ready depends
// only on the skid valid flop, so there is no combinational path from
// out_ready back to EX. A registered forwarding tap feeds the EX bypass mux.
module alu_mem_pipe_stage #(
    parameter int DATA_W = 24,
    parameter int DEST_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_wb_en,
    input  logic              in_mem_rd,
    input  logic              in_mem_wr,
    input  logic [DEST_W-1:0] in_dest,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_write_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_wb_en,
    output logic              out_mem_rd,
    output logic              out_mem_wr,
    output logic [DEST_W-1:0] out_dest,
    output logic [DATA_W-1:0] out_alu_result,
    output logic [DATA_W-1:0] out_write_data,
    output logic              fwd_valid,
    output logic [DEST_W-1:0] fwd_dest,
    output logic [DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Packed payload layout: {wb_en, mem_rd, mem_wr, dest, alu_result, write_data}
    localparam int PW = 3 + DEST_W + 2 * DATA_W;

    // State is decoded directly from {skid_valid, main_valid}
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_FULL  = 2'b01;
    localparam logic [1:0] ST_SKID  = 2'b11;

    logic          main_valid_reg, main_valid_next;
    logic          skid_valid_reg, skid_valid_next;
    logic [PW-1:0] main_payload_reg;
    logic [PW-1:0] skid_payload_reg;
    logic [PW-1:0] in_payload;
    logic [1:0]    state;
    logic          load_main_in;
    logic          load_main_skid;
    logic          load_skid;
    logic [CNT_W-1:0] stall_cnt_reg;

    assign in_payload = {in_wb_en, in_mem_rd, in_mem_wr, in_dest, in_alu_result, in_write_data};
    assign state      = {skid_valid_reg, main_valid_reg};

    // State register: valid bits, with reset taking priority over everything
    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else begin
            main_valid_reg <= main_valid_next;
            skid_valid_reg <= skid_valid_next;
        end
    end

    // Next-state and load-enable decode; flush squashes both entries and the incoming beat
    always_comb begin
        main_valid_next = main_valid_reg;
        skid_valid_next = skid_valid_reg;
        load_main_in    = 1'b0;
        load_main_skid  = 1'b0;
        load_skid       = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (in_valid) begin
                    load_main_in    = 1'b1;
                    main_valid_next = 1'b1;
                end
            end
            ST_FULL: begin
                if (out_ready) begin
                    if (in_valid) begin
                        load_main_in = 1'b1;
                    end else begin
                        main_valid_next = 1'b0;
                    end
                end else if (in_valid) begin
                    load_skid       = 1'b1;
                    skid_valid_next = 1'b1;
                end
            end
            ST_SKID: begin
                if (out_ready) begin
                    load_main_skid  = 1'b1;
                    skid_valid_next = 1'b0;
                end
            end
            default: begin
                // Skid without main is unreachable; promote the skid entry to recover
                load_main_skid  = 1'b1;
                main_valid_next = 1'b1;
                skid_valid_next = 1'b0;
            end
        endcase
        if (flush) begin
            main_valid_next = 1'b0;
            skid_valid_next = 1'b0;
            load_main_in    = 1'b0;
            load_main_skid  = 1'b0;
            load_skid       = 1'b0;
        end
    end

    // Payload registers: written only on an accepting transfer, cleared on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            main_payload_reg <= '0;
            skid_payload_reg <= '0;
        end else begin
            if (load_main_in) begin
                main_payload_reg <= in_payload;
            end else if (load_main_skid) begin
                main_payload_reg <= skid_payload_reg;
            end
            if (load_skid) begin
                skid_payload_reg <= in_payload;
            end
        end
    end

    // Saturating count of cycles where MEM holds off a valid entry
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_reg <= '0;
        end else if (main_valid_reg && !out_ready && (stall_cnt_reg != {CNT_W{1'b1}})) begin
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
    end

    // Output decode: handshake, registered fields and the forwarding tap
    always_comb begin
        in_ready  = ~skid_valid_reg;
        out_valid = main_valid_reg;
        {out_wb_en, out_mem_rd, out_mem_wr, out_dest, out_alu_result, out_write_data} = main_payload_reg;
        // Loads are not forwarded: their data is not known until MEM completes
        fwd_valid = main_valid_reg & out_wb_en & ~out_mem_rd;
        fwd_dest  = out_dest;
        fwd_data  = out_alu_result;
        stall_cnt = stall_cnt_reg;
    end

endmodule

// File: tb/tb_alu_mem_pipe_stage.sv
// Bench for alu_mem_pipe_stage: directed beats feed a scoreboard queue; a
// monitor pops and compares on every MEM-side transfer. Inputs change 1 time
// unit after the rising edge, outputs are sampled on the falling edge.
module tb_alu_mem_pipe_stage;

    localparam int DATA_W = 24;
    localparam int DEST_W = 4;
    localparam int CNT_W  = 4;

    typedef struct packed {
        logic              wb;
        logic              rd;
        logic              wr;
        logic [DEST_W-1:0] dest;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] wd;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst, flush, in_valid, in_ready;
    logic              in_wb_en, in_mem_rd, in_mem_wr;
    logic [DEST_W-1:0] in_dest;
    logic [DATA_W-1:0] in_alu_result, in_write_data;
    logic              out_valid, out_ready;
    logic              out_wb_en, out_mem_rd, out_mem_wr;
    logic [DEST_W-1:0] out_dest;
    logic [DATA_W-1:0] out_alu_result, out_write_data;
    logic              fwd_valid;
    logic [DEST_W-1:0] fwd_dest;
    logic [DATA_W-1:0] fwd_data;
    logic [CNT_W-1:0]  stall_cnt;

    int checks = 0;
    int errors = 0;
    beat_t exp_q[$];

    alu_mem_pipe_stage #(.DATA_W(DATA_W), .DEST_W(DEST_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_wb_en(in_wb_en), .in_mem_rd(in_mem_rd), .in_mem_wr(in_mem_wr),
        .in_dest(in_dest), .in_alu_result(in_alu_result), .in_write_data(in_write_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_wb_en(out_wb_en), .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr),
        .out_dest(out_dest), .out_alu_result(out_alu_result), .out_write_data(out_write_data),
        .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_data(fwd_data),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_inputs(input beat_t b);
        in_valid      = 1'b1;
        in_wb_en      = b.wb;
        in_mem_rd     = b.rd;
        in_mem_wr     = b.wr;
        in_dest       = b.dest;
        in_alu_result = b.alu;
        in_write_data = b.wd;
    endtask

    // Present a beat and hold it until accepted; returns just after the accepting edge
    task automatic drive_beat(input beat_t b);
        logic acc;
        int   waited;
        set_inputs(b);
        waited = 0;
        forever begin
            @(negedge clk);
            acc = in_ready && !rst && !flush;
            next_cycle();
            if (acc) begin
                exp_q.push_back(b);
                $display("send alu=%06h dest=%0h wb=%0b rd=%0b wr=%0b", b.alu, b.dest, b.wb, b.rd, b.wr);
                break;
            end
            waited++;
            if (waited > 50) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout alu=%06h actual=not_accepted required=accepted", b.alu);
                break;
            end
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    function automatic beat_t mk(input logic wb, input logic rd, input logic wr,
                                 input logic [DEST_W-1:0] dest, input logic [DATA_W-1:0] alu,
                                 input logic [DATA_W-1:0] wd);
        beat_t b;
        b.wb = wb; b.rd = rd; b.wr = wr; b.dest = dest; b.alu = alu; b.wd = wd;
        return b;
    endfunction

    // Monitor: every cycle with out_valid & out_ready is a transfer at the next edge
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_alu_result == 24'hABCDEF) begin
                checks++;
                errors++;
                $display("FAIL squashed_leak actual=%06h required=not_abcdef", out_alu_result);
            end
            if (!rst && !flush && out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat actual=%06h required=no_beat", out_alu_result);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_wb_en, out_mem_rd, out_mem_wr, out_dest, out_alu_result, out_write_data} !== e) begin
                        errors++;
                        $display("FAIL beat actual=alu %06h wd %06h dest %0h ctl %b%b%b required=alu %06h wd %06h dest %0h ctl %b%b%b",
                                 out_alu_result, out_write_data, out_dest, out_wb_en, out_mem_rd, out_mem_wr,
                                 e.alu, e.wd, e.dest, e.wb, e.rd, e.wr);
                    end else begin
                        $display("recv alu=%06h dest=%0h", out_alu_result, out_dest);
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        in_valid = 1'b0; in_wb_en = 1'b0; in_mem_rd = 1'b0; in_mem_wr = 1'b0;
        in_dest = '0; in_alu_result = '0; in_write_data = '0;
        repeat (2) next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_in_ready", in_ready, 1);
        check("reset_stall_cnt", stall_cnt, 0);
        check("reset_alu", out_alu_result, 0);
        check("reset_dest", out_dest, 0);
        check("reset_fwd_valid", fwd_valid, 0);
        next_cycle();

        // Single beat with forwarding
        drive_beat(mk(1, 0, 0, 4'h3, 24'h001234, 24'h000000));
        idle();
        check("one_out_valid", out_valid, 1);
        check("one_fwd_valid", fwd_valid, 1);
        check("one_fwd_dest", fwd_dest, 3);
        check("one_fwd_data", fwd_data, 32'h001234);
        next_cycle();

        // Streaming: one beat per cycle, no bubbles
        for (int i = 1; i <= 8; i++) begin
            check("stream_in_ready", in_ready, 1);
            drive_beat(mk(1, 0, 0, 4'h1, DATA_W'(i), 24'h0));
            check("stream_alu", out_alu_result, i);
            check("stream_out_valid", out_valid, 1);
        end
        idle();
        repeat (2) next_cycle();

        // Backpressure into the skid entry
        drive_beat(mk(1, 0, 0, 4'h2, 24'd10, 24'h0));
        out_ready = 1'b0;
        drive_beat(mk(1, 0, 0, 4'h2, 24'd11, 24'h0));
        set_inputs(mk(1, 0, 0, 4'h2, 24'd12, 24'h0));
        check("bp_in_ready", in_ready, 0);
        check("bp_stall_1", stall_cnt, 1);
        for (int k = 2; k <= 4; k++) begin
            next_cycle();
            check("bp_hold_main", out_alu_result, 10);
            check("bp_hold_in_ready", in_ready, 0);
            check("bp_stall_cnt", stall_cnt, k);
        end
        out_ready = 1'b1;
        drive_beat(mk(1, 0, 0, 4'h2, 24'd12, 24'h0));
        idle();
        repeat (2) next_cycle();
        check("bp_drained", exp_q.size(), 0);

        // Flush while in SKID, with a beat presented the same cycle
        out_ready = 1'b0;
        drive_beat(mk(1, 0, 0, 4'h6, 24'h000020, 24'h0));
        drive_beat(mk(1, 0, 0, 4'h6, 24'h000021, 24'h0));
        check("fl_skid_in_ready", in_ready, 0);
        set_inputs(mk(1, 0, 0, 4'h6, 24'hABCDEF, 24'h0));
        flush = 1'b1;
        next_cycle();
        flush = 1'b0;
        idle();
        exp_q.delete();
        check("fl_out_valid", out_valid, 0);
        check("fl_in_ready", in_ready, 1);
        check("fl_fwd_valid", fwd_valid, 0);
        out_ready = 1'b1;
        repeat (2) next_cycle();
        check("fl_still_empty", out_valid, 0);

        // Load does not forward; store without writeback does not forward
        drive_beat(mk(1, 1, 0, 4'h5, 24'h000055, 24'h000066));
        check("ld_out_valid", out_valid, 1);
        check("ld_fwd_valid", fwd_valid, 0);
        drive_beat(mk(0, 0, 1, 4'h7, 24'h000100, 24'h00BEEF));
        idle();
        check("st_fwd_valid", fwd_valid, 0);
        check("st_write_data", out_write_data, 32'h00BEEF);
        next_cycle();

        // Stall counter saturation and bit-stable hold
        out_ready = 1'b0;
        drive_beat(mk(1, 0, 0, 4'h9, 24'h000077, 24'h000011));
        idle();
        repeat ((1 << CNT_W) + 3) next_cycle();
        check("sat_stall_cnt", stall_cnt, 15);
        check("sat_hold_alu", out_alu_result, 32'h000077);
        check("sat_hold_wd", out_write_data, 32'h000011);

        // Reset beats flush and the handshake
        set_inputs(mk(1, 0, 0, 4'hA, 24'h000099, 24'h0));
        out_ready = 1'b1;
        rst = 1'b1;
        flush = 1'b1;
        next_cycle();
        rst = 1'b0;
        flush = 1'b0;
        idle();
        exp_q.delete();
        @(negedge clk);
        check("rst2_out_valid", out_valid, 0);
        check("rst2_stall_cnt", stall_cnt, 0);
        check("rst2_alu", out_alu_result, 0);
        check("rst2_dest", out_dest, 0);
        check("rst2_in_ready", in_ready, 1);
        check("rst2_fwd_valid", fwd_valid, 0);
        next_cycle();
        check("final_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
